// File: rtl/mul_sched.sv
// Shares one pipelined multiplier between two requesters: round-robin issue with
// response credits, owner tracking through the multiplier latency, per-requester response FIFOs.
module mul_sched #(
  parameter int XLEN   = 64,
  parameter int LAT    = 1,
  parameter int RDEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ReqValid,
  output logic [1:0]        ReqReady,
  input  logic [2*XLEN-1:0] ReqA,
  input  logic [2*XLEN-1:0] ReqB,
  input  logic [5:0]        ReqFunct3,
  output logic [1:0]        RspValid,
  input  logic [1:0]        RspReady,
  output logic [2*XLEN-1:0] RspData,
  output logic [XLEN-1:0]   MulAE,
  output logic [XLEN-1:0]   MulBE,
  output logic [2:0]        MulFunct3E,
  input  logic [2*XLEN-1:0] MulProdM
);

  localparam int CW = 3;
  localparam int PW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(RDEPTH);

  logic [CW-1:0]   occ      [2];
  logic [CW-1:0]   inflight [2];
  logic [PW-1:0]   wr_ptr   [2];
  logic [PW-1:0]   rd_ptr   [2];
  logic [XLEN-1:0] mem      [2][RDEPTH];
  logic            last_gnt;

  logic [LAT-1:0]  pv, pid, phi;
  logic [1:0]      elig, gnt, push, pop;
  logic            issue, retire, rid;
  logic [XLEN-1:0] rdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RDEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Both sides use valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high. ReqReady is the grant and depends on ReqValid; RspValid
  // depends only on registered occupancy, never on RspReady.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++)
      elig[i] = ReqValid[i] && (({1'b0, occ[i]} + {1'b0, inflight[i]}) < DEPTH_C);
    gnt = '0;
    if (!reset)
      gnt = '0;
    else if (elig == 2'b11)
      gnt = last_gnt ? 2'b01 : 2'b10;
    else
      gnt = elig;
  end

  assign ReqReady = gnt;
  assign issue    = |gnt;

  // Idle cycles drive zero operands so the multiplier computes a harmless bubble.
  always_comb begin
    MulAE      = '0;
    MulBE      = '0;
    MulFunct3E = '0;
    if (gnt[0]) begin
      MulAE      = ReqA[XLEN-1:0];
      MulBE      = ReqB[XLEN-1:0];
      MulFunct3E = ReqFunct3[2:0];
    end else if (gnt[1]) begin
      MulAE      = ReqA[2*XLEN-1:XLEN];
      MulBE      = ReqB[2*XLEN-1:XLEN];
      MulFunct3E = ReqFunct3[5:3];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv  <= '0;
      pid <= '0;
      phi <= '0;
    end else begin
      pv[0]  <= issue;
      pid[0] <= gnt[1];
      phi[0] <= (MulFunct3E != 3'b000);
      for (int k = 1; k < LAT; k++) begin
        pv[k]  <= pv[k-1];
        pid[k] <= pid[k-1];
        phi[k] <= phi[k-1];
      end
    end
  end

  assign retire = pv[LAT-1];
  assign rid    = pid[LAT-1];
  assign rdata  = phi[LAT-1] ? MulProdM[2*XLEN-1:XLEN] : MulProdM[XLEN-1:0];

  always_comb begin
    push    = '0;
    pop     = '0;
    RspData = '0;
    for (int i = 0; i < 2; i++) begin
      RspValid[i]               = (occ[i] != '0);
      push[i]                   = retire && (rid == 1'(i));
      pop[i]                    = RspValid[i] && RspReady[i];
      RspData[i*XLEN +: XLEN]   = mem[i][rd_ptr[i]];
    end
  end

  // Credits (occ + inflight) bound the FIFO, so a push never meets a full buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        occ[i]      <= '0;
        inflight[i] <= '0;
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        for (int d = 0; d < RDEPTH; d++) mem[i][d] <= '0;
      end
    end else begin
      if (issue) last_gnt <= gnt[1];
      for (int i = 0; i < 2; i++) begin
        if (gnt[i] && !push[i])      inflight[i] <= inflight[i] + CW'(1);
        else if (!gnt[i] && push[i]) inflight[i] <= inflight[i] - CW'(1);
        if (push[i] && !pop[i])      occ[i] <= occ[i] + CW'(1);
        else if (pop[i] && !push[i]) occ[i] <= occ[i] - CW'(1);
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= rdata;
          wr_ptr[i]         <= ptr_inc(wr_ptr[i]);
        end
        if (pop[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
      end
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched (XLEN=32, LAT=1, RDEPTH=2) with a one-stage multiplier model
// and a per-requester expected-response queue.
module tb_mul_sched;
  localparam int XLEN = 32;

  logic        clk, rst_n;
  logic [1:0]  ReqValid, ReqReady, RspValid, RspReady;
  logic [63:0] ReqA, ReqB, RspData, MulProdM;
  logic [5:0]  ReqFunct3;
  logic [31:0] MulAE, MulBE;
  logic [2:0]  MulFunct3E;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [31:0] exp;
  } vec_t;

  vec_t        vq0[$], vq1[$];
  logic [31:0] exp_q0[$], exp_q1[$];
  int          gnt_hist[$];
  int          checks = 0, failures = 0;

  mul_sched #(.XLEN(32), .LAT(1), .RDEPTH(2)) dut (
    .clk(clk), .reset(rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqA(ReqA), .ReqB(ReqB), .ReqFunct3(ReqFunct3), .RspValid(RspValid),
    .RspReady(RspReady), .RspData(RspData), .MulAE(MulAE), .MulBE(MulBE),
    .MulFunct3E(MulFunct3E), .MulProdM(MulProdM)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // free-running multiplier, one register stage
  logic [31:0] ma = '0, mb = '0;
  logic [2:0]  mf = '0;
  logic signed [32:0] xa, xb;
  logic signed [65:0] xp;
  always @(posedge clk) begin
    ma <= MulAE;
    mb <= MulBE;
    mf <= MulFunct3E;
  end
  always_comb begin
    xa = {(mf == 3'b001 || mf == 3'b010) & ma[31], ma};
    xb = {(mf == 3'b001) & mb[31], mb};
    xp = xa * xb;
    MulProdM = xp[63:0];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] f3, input logic [31:0] exp);
    vec_t v;
    v.a = a; v.b = b; v.f3 = f3; v.exp = exp;
    return v;
  endfunction

  // driver: present each requester's queue head after every rising edge
  task automatic drive_req();
    ReqValid  = '0;
    ReqA      = '0;
    ReqB      = '0;
    ReqFunct3 = '0;
    if (vq0.size() != 0) begin
      ReqValid[0] = 1'b1; ReqA[31:0] = vq0[0].a; ReqB[31:0] = vq0[0].b; ReqFunct3[2:0] = vq0[0].f3;
    end
    if (vq1.size() != 0) begin
      ReqValid[1] = 1'b1; ReqA[63:32] = vq1[0].a; ReqB[63:32] = vq1[0].b; ReqFunct3[5:3] = vq1[0].f3;
    end
  endtask

  initial begin
    drive_req();
    forever begin
      @(posedge clk);
      #1;
      drive_req();
    end
  end

  // issue side: a granted request retires its vector and queues its expected result
  always @(negedge clk) begin
    if (rst_n) begin
      check("rdy_without_valid", ReqReady & ~ReqValid, 0);
      if (ReqValid[0] && ReqReady[0]) begin
        exp_q0.push_back(vq0[0].exp);
        void'(vq0.pop_front());
        gnt_hist.push_back(0);
      end
      if (ReqValid[1] && ReqReady[1]) begin
        exp_q1.push_back(vq1[0].exp);
        void'(vq1.pop_front());
        gnt_hist.push_back(1);
      end
    end
  end

  // monitor: compare every accepted response against the expected queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (RspValid[0] && RspReady[0]) begin
        if (exp_q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp0_unexpected actual=%h required=none", RspData[31:0]);
        end else check("rsp0_data", RspData[31:0], exp_q0.pop_front());
      end
      if (RspValid[1] && RspReady[1]) begin
        if (exp_q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp1_unexpected actual=%h required=none", RspData[63:32]);
        end else check("rsp1_data", RspData[63:32], exp_q1.pop_front());
      end
    end
  end

  task automatic clear_all();
    vq0.delete(); vq1.delete(); exp_q0.delete(); exp_q1.delete();
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((vq0.size() + vq1.size() + exp_q0.size() + exp_q1.size()) != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, vq0.size() + vq1.size() + exp_q0.size() + exp_q1.size(), 0);
  endtask

  initial begin
    int g, r, n0;
    bit found;
    logic [11:0] gb, rb;
    rst_n    = 1'b0;
    RspReady = 2'b11;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_reqready", ReqReady, 0);
    check("rst_rspvalid", RspValid, 0);
    check("rst_rspdata", RspData, 0);
    check("rst_mulae", MulAE, 0);
    check("rst_mulbe", MulBE, 0);
    check("rst_mulf3", MulFunct3E, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single MUL, response two cycles after grant
    @(negedge clk);
    vq0.push_back(mk(32'd3, 32'd5, 3'b000, 32'd15));
    g = -1; r = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ReqReady[0] && g < 0) g = k;
      if (RspValid[0] && r < 0) r = k;
      if (r >= 0) break;
    end
    check("t1_grant_seen", g, 0);
    check("t1_latency", r - g, 2);
    wait_drain("t1_drain");

    // high-half selection for each multiply type on requester 1
    vq1.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 32'h00000000));
    vq1.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'hFFFFFFFE));
    vq1.push_back(mk(32'hFFFFFFFF, 32'd2,        3'b010, 32'hFFFFFFFF));
    vq1.push_back(mk(32'd2,        32'hFFFFFFFF, 3'b010, 32'h00000001));
    vq1.push_back(mk(32'hFFFFFFFF, 32'd2,        3'b000, 32'hFFFFFFFE));
    vq1.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100, 32'hFFFFFFFE));
    wait_drain("t2_drain");

    // both requesters valid from reset: strict alternation starting at requester 0
    @(posedge clk); #1 rst_n = 1'b0;
    clear_all();
    vq0.push_back(mk(32'd2,      32'd3,       3'b000, 32'd6));
    vq0.push_back(mk(32'd7,      32'd8,       3'b000, 32'd56));
    vq0.push_back(mk(32'd100,    32'd100,     3'b000, 32'd10000));
    vq0.push_back(mk(32'h0000FFFF, 32'h00010001, 3'b000, 32'hFFFFFFFF));
    vq1.push_back(mk(32'd5,      32'd5,       3'b000, 32'd25));
    vq1.push_back(mk(32'd12,     32'd12,      3'b000, 32'd144));
    vq1.push_back(mk(32'd9,      32'd11,      3'b000, 32'd99));
    vq1.push_back(mk(32'd1000,   32'd1000,    3'b000, 32'd1000000));
    @(posedge clk);
    @(negedge clk);
    check("t3_rst_valid", ReqValid, 2'b11);
    check("t3_rst_ready", ReqReady, 0);
    gnt_hist.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    wait_drain("t3_drain");
    check("t3_gnt_count", gnt_hist.size(), 8);
    for (int k = 0; k < 8; k++)
      check("t3_gnt_order", (k < gnt_hist.size()) ? gnt_hist[k] : -1, k % 2);

    // lone requester: credits allow two of every three cycles; push+pop keep occupancy
    @(negedge clk);
    for (int k = 0; k < 6; k++) vq0.push_back(mk(k + 1, 32'd100, 3'b000, (k + 1) * 100));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      gb[k] = ReqReady[0];
      rb[k] = RspValid[0];
    end
    check("t5_grant_pattern", gb, 12'h0DB);
    check("t5_rspvalid_pattern", rb, 12'h36C);
    wait_drain("t5_drain");

    // stalled consumer 0: two grants then blocked; a single pop frees exactly one grant
    @(posedge clk); #1 RspReady = 2'b10;
    @(negedge clk);
    for (int k = 0; k < 6; k++)  vq0.push_back(mk(k + 3, 32'd10, 3'b000, (k + 3) * 10));
    for (int k = 0; k < 20; k++) vq1.push_back(mk(k, k + 1, 3'b000, k * (k + 1)));
    n0 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n0 += int'(ReqReady[0]);
      if (k >= 5) check("t4_blocked", ReqReady[0], 0);
    end
    check("t4_grant_count", n0, 2);
    @(posedge clk); #1 RspReady = 2'b11;
    @(posedge clk); #1 RspReady = 2'b10;
    @(negedge clk);
    check("t4_pulse_grant", ReqReady[0], 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_reblocked", ReqReady[0], 0);
    end
    @(posedge clk); #1 RspReady = 2'b11;
    wait_drain("t4_drain");

    // reset with an operation in flight: it must vanish
    @(negedge clk);
    vq0.push_back(mk(32'd4, 32'd4, 3'b000, 32'd16));
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ReqReady[0]) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_issue_seen", found, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    clear_all();
    #1;
    check("t6_rst_rspvalid", RspValid, 0);
    check("t6_rst_reqready", ReqReady, 0);
    check("t6_rst_rspdata", RspData, 0);
    @(negedge clk);
    vq0.push_back(mk(32'd6, 32'd7, 3'b000, 32'd42));
    vq1.push_back(mk(32'd2, 32'd9, 3'b000, 32'd18));
    gnt_hist.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    wait_drain("t6_drain");
    check("t6_first_gnt", (gnt_hist.size() > 0) ? gnt_hist[0] : -1, 0);

    repeat (4) @(negedge clk);
    check("end_rspvalid", RspValid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
